// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register offsets,
// TCON bit positions, prescaler width and the default bus base address.
package timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [31:0] OFF_TH   = 32'd0;
    localparam logic [31:0] OFF_TL   = 32'd4;
    localparam logic [31:0] OFF_TCON = 32'd8;
    localparam logic [31:0] OFF_PSC  = 32'd12;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    localparam int PSC_WIDTH = 16;

endpackage

// File: rtl/timer_irq_unit_if.sv
// Data-memory bus slice seen by the timer: CPU strobes, address and store data
// in, combinational read data and address-hit out.
interface timer_irq_unit_if;

    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output mem_rd, mem_wr, addr, wdata,
        input  rdata, hit
    );

    modport slave (
        input  mem_rd, mem_wr, addr, wdata,
        output rdata, hit
    );

endinterface

// File: rtl/timer_prescaler.sv
// Tick generator used when TIMER_PRESCALE_EN is defined: holds PSC and a
// free-running prescale counter that emits one tick every PSC+1 enabled cycles.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
    import timer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 psc_we_i,
    input  logic [PSC_WIDTH-1:0] psc_wdata_i,
    output logic                 tick_o,
    output logic [PSC_WIDTH-1:0] psc_o
);

    logic [PSC_WIDTH-1:0] psc_q, psc_d;
    logic [PSC_WIDTH-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == psc_q);
    assign psc_o  = psc_q;

    always_comb begin
        psc_d = psc_q;
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + PSC_WIDTH'(1);
        end
        // A new prescale value restarts the period from zero.
        if (psc_we_i) begin
            psc_d = psc_wdata_i;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            psc_q <= '0;
            cnt_q <= '0;
        end else begin
            psc_q <= psc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/timer_irq_unit.sv
// Memory-mapped interval timer (TH reload, TL count, TCON control) driving a
// sticky irq. Define TIMER_PRESCALE_EN to add the PSC register and prescaler.
module timer_irq_unit
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          WIDTH     = 32
) (
    input  logic              clk,
    input  logic              reset,
    timer_irq_unit_if.slave   bus,
    output logic              irq
);

    localparam logic [WIDTH-1:0] TL_MAX = '1;

    logic [WIDTH-1:0]     th_q, th_d;
    logic [WIDTH-1:0]     tl_q, tl_d;
    logic [2:0]           tcon_q, tcon_d;
    logic [31:0]          offset;
    logic                 sel_th, sel_tl, sel_tcon, sel_psc;
    logic                 wr_en;
    logic                 tick, overflow, ovf_set;
    logic [PSC_WIDTH-1:0] psc_val;

    // Exact-offset compares reject unaligned and out-of-window addresses.
    assign offset   = bus.addr - BASE_ADDR;
    assign sel_th   = (offset == OFF_TH);
    assign sel_tl   = (offset == OFF_TL);
    assign sel_tcon = (offset == OFF_TCON);
    assign wr_en    = bus.mem_wr;

`ifdef TIMER_PRESCALE_EN
    assign sel_psc = (offset == OFF_PSC);

    timer_prescaler u_prescaler (
        .clk         (clk),
        .reset       (reset),
        .en_i        (tcon_q[TCON_EN]),
        .psc_we_i    (wr_en && sel_psc),
        .psc_wdata_i (bus.wdata[PSC_WIDTH-1:0]),
        .tick_o      (tick),
        .psc_o       (psc_val)
    );
`else
    assign sel_psc = 1'b0;
    assign tick    = tcon_q[TCON_EN];
    assign psc_val = '0;
`endif

    assign bus.hit  = sel_th || sel_tl || sel_tcon || sel_psc;
    assign overflow = tick && (tl_q == TL_MAX);
    assign ovf_set  = overflow && tcon_q[TCON_IE];
    assign irq      = tcon_q[TCON_IS] & tcon_q[TCON_IE];

    always_comb begin
        bus.rdata = '0;
        if (bus.mem_rd) begin
            if (sel_th)   bus.rdata = 32'(th_q);
            if (sel_tl)   bus.rdata = 32'(tl_q);
            if (sel_tcon) bus.rdata = {29'd0, tcon_q};
            if (sel_psc)  bus.rdata = 32'(psc_val);
        end
    end

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        if (tick) begin
            tl_d = overflow ? th_q : tl_q + WIDTH'(1);
        end
        if (ovf_set) begin
            tcon_d[TCON_IS] = 1'b1;
        end
        // Bus writes override counting; a TCON clear never drops a fresh overflow.
        if (wr_en && sel_th) begin
            th_d = bus.wdata[WIDTH-1:0];
        end
        if (wr_en && sel_tl) begin
            tl_d = bus.wdata[WIDTH-1:0];
        end
        if (wr_en && sel_tcon) begin
            tcon_d = {bus.wdata[TCON_IS] | ovf_set, bus.wdata[TCON_IE], bus.wdata[TCON_EN]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= 3'b000;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

endmodule

// File: tb/tb_timer_irq_unit.sv
// Randomized scoreboard bench for timer_irq_unit: a behavioural register model
// predicts rdata/hit/irq per cycle; a negedge monitor pops and compares.
module tb_timer_irq_unit;
    import timer_pkg::*;

    localparam logic [31:0] BASE = DEFAULT_BASE_ADDR;

    logic clk = 1'b0;
    logic reset;
    logic irq;

    timer_irq_unit_if bus ();

    timer_irq_unit #(.BASE_ADDR(BASE), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        hit;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [31:0] m_th, m_tl;
    logic        m_en, m_ie, m_is;
    int unsigned m_psc, m_pcnt;

    function automatic int m_slot(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off[1:0] != 2'b00 || off > 32'd12) return -1;
`ifndef TIMER_PRESCALE_EN
        if (off == 32'd12) return -1;
`endif
        return int'(off) / 4;
    endfunction

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_en = 0; m_ie = 0; m_is = 0; m_psc = 0; m_pcnt = 0;
    endtask

    task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic rst_n);
        int          s;
        logic        tick, ovf, set_is, next_is;
        logic [31:0] next_tl;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s = m_slot(a);
`ifdef TIMER_PRESCALE_EN
        tick = m_en && (m_pcnt == m_psc);
        if (m_en) m_pcnt = tick ? 0 : m_pcnt + 1;
`else
        tick = m_en;
`endif
        ovf     = tick && (m_tl == 32'hFFFF_FFFF);
        set_is  = ovf && m_ie;
        next_tl = !tick ? m_tl : (ovf ? m_th : m_tl + 1);
        next_is = m_is | set_is;
        if (wr && s >= 0) begin
            case (s)
                0: m_th = d;
                1: next_tl = d;
                2: begin m_en = d[0]; m_ie = d[1]; next_is = d[2] | set_is; end
                default: begin m_psc = d[15:0]; m_pcnt = 0; end
            endcase
        end
        m_tl = next_tl;
        m_is = next_is;
    endtask

    // Drive one bus cycle, queue the predicted outputs, advance the model.
    task automatic cycle(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic rst_n, input string tag);
        exp_t e;
        int   s;
        s = m_slot(a);
        bus.mem_rd = rd;
        bus.mem_wr = wr;
        bus.addr   = a;
        bus.wdata  = d;
        reset      = rst_n;
        e.hit   = (s >= 0);
        e.irq   = m_is & m_ie;
        e.rdata = 32'd0;
        if (rd && s >= 0) begin
            case (s)
                0: e.rdata = m_th;
                1: e.rdata = m_tl;
                2: e.rdata = {29'd0, m_is, m_ie, m_en};
                default: e.rdata = m_psc;
            endcase
        end
        e.tag = tag;
        exp_q.push_back(e);
        model_step(wr, a, d, rst_n);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input string tag);
        cycle(1'b0, 1'b1, a, d, 1'b1, tag);
    endtask

    task automatic rd_reg(input logic [31:0] a, input string tag);
        cycle(1'b1, 1'b0, a, 32'd0, 1'b1, tag);
    endtask

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h expected %h", e.tag, bus.rdata, e.rdata);
                end
                n_checks++;
                if (bus.hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL %s hit: got %b expected %b", e.tag, bus.hit, e.hit);
                end
                n_checks++;
                if (irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s irq: got %b expected %b", e.tag, irq, e.irq);
                end
                $display("txn %s rd=%b wr=%b addr=%h rdata=%h hit=%b irq=%b", e.tag,
                         bus.mem_rd, bus.mem_wr, bus.addr, bus.rdata, bus.hit, irq);
            end
        end
    end

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 9))
            0, 1: return BASE;
            2, 3: return BASE + 32'd4;
            4, 5: return BASE + 32'd8;
            6:    return BASE + 32'd12;
            7:    return BASE + 32'd2;
            8:    return BASE + 32'd16;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_data(input logic [31:0] a);
        if (a == BASE + 32'd8)  return {29'd0, 1'b0, 1'b1, 1'b1} | 32'($urandom_range(0, 7));
        if (a == BASE + 32'd12) return 32'($urandom_range(0, 4));
        if ($urandom_range(0, 1) == 1) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return $urandom;
    endfunction

    initial begin
        logic [31:0] a;
        reset      = 1'b0;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        bus.addr   = 32'd0;
        bus.wdata  = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset after random writes, with a write colliding with reset
        for (int i = 0; i < 6; i++) begin
            a = pick_addr();
            wr_reg(a, pick_data(a), "rst_pre");
        end
        cycle(1'b0, 1'b1, BASE + 32'd4, 32'h1234, 1'b0, "rst_wr");
        cycle(1'b0, 1'b0, BASE, 32'd0, 1'b0, "rst_hold");
        for (int i = 0; i < 4; i++) rd_reg(BASE + 32'(4 * i), "rst_rd");

        // Basic overflow with reload every 3 ticks
        wr_reg(BASE, 32'hFFFF_FFFD, "ovf_th");
        wr_reg(BASE + 32'd4, 32'hFFFF_FFFD, "ovf_tl");
        wr_reg(BASE + 32'd8, 32'd3, "ovf_tcon");
        for (int i = 0; i < 8; i++) rd_reg(BASE + 32'd4, "ovf_tl_rd");

        // Sticky clear, then overflow with irq disabled
        wr_reg(BASE + 32'd8, 32'd3, "clr_tcon");
        rd_reg(BASE + 32'd8, "clr_rd");
        wr_reg(BASE + 32'd8, 32'd1, "ie_off");
        for (int i = 0; i < 5; i++) rd_reg(BASE + 32'd4, "ie_off_rd");

        // TCON write colliding with overflow
        wr_reg(BASE + 32'd8, 32'd0, "col_stop");
        wr_reg(BASE, 32'd10, "col_th");
        wr_reg(BASE + 32'd4, 32'hFFFF_FFFE, "col_tl");
        wr_reg(BASE + 32'd8, 32'd3, "col_en");
        rd_reg(BASE + 32'd4, "col_tl_rd");
        wr_reg(BASE + 32'd8, 32'd3, "col_tcon");
        rd_reg(BASE + 32'd8, "col_tcon_rd");
        rd_reg(BASE + 32'd4, "col_tl_rd2");

        // TL write and TH write colliding with overflow
        wr_reg(BASE + 32'd4, 32'hFFFF_FFFE, "colw_tl");
        rd_reg(BASE + 32'd4, "colw_rd");
        wr_reg(BASE + 32'd4, 32'd5, "colw_tl5");
        rd_reg(BASE + 32'd4, "colw_rd5");
        wr_reg(BASE + 32'd4, 32'hFFFF_FFFF, "colh_tl");
        wr_reg(BASE, 32'd77, "colh_th");
        rd_reg(BASE + 32'd4, "colh_rd");

        // Bus decode
        wr_reg(BASE + 32'd2, 32'hDEAD_BEEF, "dec_unal");
        wr_reg(BASE + 32'd16, 32'hDEAD_BEEF, "dec_out");
        rd_reg(BASE + 32'd2, "dec_rd_unal");
        rd_reg(BASE + 32'd16, "dec_rd_out");
        cycle(1'b0, 1'b0, BASE + 32'd4, 32'd0, 1'b1, "dec_nord");
        rd_reg(BASE, "dec_th");

        // Prescaler (unmapped PSC when the feature is absent)
        wr_reg(BASE + 32'd8, 32'd0, "psc_stop");
        wr_reg(BASE + 32'd12, 32'd3, "psc_wr");
        wr_reg(BASE + 32'd4, 32'd0, "psc_tl");
        wr_reg(BASE + 32'd8, 32'd1, "psc_en");
        for (int i = 0; i < 10; i++) rd_reg(BASE + 32'd4, "psc_tl_rd");
        rd_reg(BASE + 32'd12, "psc_rd");
        wr_reg(BASE + 32'd12, 32'd0, "psc_zero");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            a = pick_addr();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rd_reg(a, "rnd_rd");
                4, 5:       wr_reg(a, pick_data(a), "rnd_wr");
                6:          cycle(1'b1, 1'b1, a, pick_data(a), 1'b1, "rnd_rdwr");
                default:    cycle(1'b0, 1'b0, a, 32'd0,
                                  ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, "rnd_idle");
            endcase
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_irq_unit.md
Name: timer_irq_unit

Overview:
- Memory-mapped interval timer that produces the `irq` request consumed by the Control decoder of the single-cycle MIPS core.
- Sits on the data-memory bus beside RAM. The CPU loads the reload value (TH), the count (TL) and the control word (TCON).
- On counter overflow the timer raises a sticky interrupt flag, which drives `irq` until software clears it.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of TH; TL = BASE+4, TCON = BASE+8, PSC = BASE+12.
- WIDTH, 32, width of TH and TL.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-low reset
- mem_rd  input  1  bus read strobe from the CPU
- mem_wr  input  1  bus write strobe from the CPU
- addr  input  32  byte address from the ALU result
- wdata  input  32  store data (rt)
- rdata  output  32  read data, zero when not selected
- hit  output  1  addr falls in BASE..BASE+12, word-aligned
- irq  output  1  interrupt request to the Control irq input

Behaviour:
- Clock and reset (already decided): one clock, `clk`; reset is synchronous and active-low on port `reset`.
- Reset (`reset`==0 at a clk edge): TH=0, TL=0, TCON=3'b000, PSC=0, prescale counter=0. Effect: irq=0, rdata=0 when no read.
- Registers:
  - TH[WIDTH-1:0] and TL[WIDTH-1:0].
  - TCON[2:0]: bit0 = enable, bit1 = irq enable, bit2 = irq status.
- Reads are combinational, same cycle, to match single-cycle load timing.
  - If mem_rd && hit: rdata = selected register, zero-extended to 32 bits. Otherwise rdata = 0.
- Writes take effect at the clk edge when mem_wr && hit. Unaligned or unmapped addresses are ignored.
- Tick generation: a tick occurs each cycle that TCON[0]=1 (PSC path: see Optional Feature).
- On a tick:
  - If TL == all-ones: TL <= TH, and if TCON[1]=1 then TCON[2] <= 1.
  - Else: TL <= TL+1, wrapping at WIDTH.
- TCON[2] is sticky. It is cleared only by a TCON write with wdata[2]=0, or by reset. Writing wdata[2]=1 sets it (software-raised irq, used by tests).
- irq = TCON[2] & TCON[1], registered-state only (no combinational path from the bus to irq).
- Simultaneous events:
  - A CPU write to TL in the same cycle as a tick: the write wins, and no increment or reload occurs that cycle.
  - A TCON write in the same cycle as an overflow that would set bit2: bit2 = wdata[2] | overflow_set. A clear never loses a fresh overflow.
  - A TH write during an overflow cycle: the reload uses the old TH; the new TH applies at the next overflow.
- Clearing TCON[0] freezes TL and the prescale counter and keeps TCON[2] as-is.
- Reset asserted mid-count overrides all writes and ticks in that cycle.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - PSC[15:0] is readable/writable at BASE+12.
  - A 16-bit prescale counter increments while TCON[0]=1. A tick is issued when it equals PSC, and it then returns to 0.
  - PSC=0 gives a tick every cycle. PSC=N gives a tick every N+1 cycles.
  - A write to PSC also clears the prescale counter.
- Undefined:
  - Tick every enabled cycle. BASE+12 is not mapped: hit=0, reads return 0, writes are ignored.

Decomposition:
- Shared package timer_pkg holds:
  - the register offsets (OFF_TH=0, OFF_TL=4, OFF_TCON=8, OFF_PSC=12);
  - the TCON bit indices (TCON_EN=0, TCON_IE=1, TCON_IS=2);
  - the default BASE_ADDR.
- One sub-module, timer_prescaler (tick generator), is instantiated only under TIMER_PRESCALE_EN. Otherwise tick = TCON[0].

Test Plan:
- Reset: hold reset=0 for 2 cycles after random writes -> all registers read 0, irq=0.
- Basic overflow: TH=32'hFFFF_FFFD, TL=32'hFFFF_FFFD, TCON=3'b011.
  - TL reads FFFF_FFFE, then FFFF_FFFF.
  - On the next tick TL=FFFF_FFFD and irq=1 one cycle after the overflow edge.
  - The next reload repeats every 3 ticks.
- Sticky/clear: with irq=1, write TCON=3'b011 -> irq falls at the next edge.
  - With TCON[1]=0, an overflow reloads TL but irq stays 0.
- Collisions:
  - Write TCON=3'b011 in the exact overflow cycle -> TCON reads 3'b111.
  - Write TL=5 in an overflow cycle -> TL=5, no reload.
- Bus decode: write to BASE+2 and BASE+16 -> no register changes, hit=0. A read with mem_rd=0 -> rdata=0.
- TIMER_PRESCALE_EN: PSC=3, TL=0, TCON=1 -> TL increments once per 4 cycles (0,0,0,0,1...).
  - Without the macro, a read of BASE+12 returns 0.
